// File: rtl/bus_interrupt_controller_pkg.sv
// rtl/bus_interrupt_controller_pkg.sv - shared constants and types for the bus interrupt controller
package bus_interrupt_controller_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_VECTOR  = 2'd2;
    localparam logic [1:0] REG_EDGE    = 2'd3;

    // Bit position of the valid flag in the VECTOR register
    localparam int VEC_VALID_BIT = 7;

    // Processor handshake state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } irq_state_e;

endpackage

// File: rtl/bus_interrupt_controller_if.sv
// rtl/bus_interrupt_controller_if.sv - bus control, source handshake and cpu handshake bundle
interface bus_interrupt_controller_if;

    // Source lines are sized for the maximum of eight channels; narrower
    // controllers use the low NUM_CH bits and tie the rest of src_ack low.
    logic [7:0] bus_addr;
    logic       bus_we;
    logic [7:0] src_raise;
    logic [7:0] src_ack;
    logic       cpu_int_raise;
    logic       cpu_int_ack;

    modport slave (
        input  bus_addr,
        input  bus_we,
        input  src_raise,
        input  cpu_int_ack,
        output src_ack,
        output cpu_int_raise
    );

    modport master (
        output bus_addr,
        output bus_we,
        output src_raise,
        output cpu_int_ack,
        input  src_ack,
        input  cpu_int_raise
    );

endinterface

// File: rtl/bus_interrupt_controller_irq_rr_arbiter.sv
// rtl/bus_interrupt_controller_irq_rr_arbiter.sv - rotating priority encoder over the eligible set
module irq_rr_arbiter #(
    parameter int NUM_CH = 8,
    localparam int IDXW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [IDXW-1:0]   start_ptr,
    output logic [IDXW-1:0]   winner,
    output logic              any_valid
);

    // Scan from start_ptr upwards, wrapping at NUM_CH-1; first hit wins
    always_comb begin
        int          idx;
        logic [IDXW-1:0] sel;
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(start_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            sel = IDXW'(idx);
            if (!any_valid && eligible[sel]) begin
                any_valid = 1'b1;
                winner    = sel;
            end
        end
    end

endmodule

// File: rtl/bus_interrupt_controller.sv
// rtl/bus_interrupt_controller.sv - memory-mapped interrupt aggregator with cpu raise/ack handshake
module bus_interrupt_controller
    import bus_interrupt_controller_pkg::*;
#(
    parameter int         NUM_CH    = 8,
    parameter logic [7:0] BASE_ADDR = 8'hE0,
    parameter bit         RR_MODE   = 1'b0
) (
    input  logic   clk,
    input  logic   reset,
    inout  wire [7:0] bus_data,
    bus_interrupt_controller_if.slave bus
);

    localparam int IDXW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] pending_q, mask_q, edge_q, raise_d, src_ack_q;
    logic [NUM_CH-1:0] raise, capture, w1c, ack_clr, pending_n, eligible, wdata;
    logic [IDXW-1:0]   vector_q, rr_ptr_q, arb_ptr, winner, vector_inc;
    logic              vec_valid_q, any_valid;
    irq_state_e        state_q, state_n;

    logic [7:0] offset;
    logic [1:0] reg_sel;
    logic       addr_hit, wr_en, rd_en;
    logic [7:0] rd_mux, rd_data_q;
    logic       rd_oe;

    // Address decode: the subtraction wraps, so only the four addresses
    // starting at BASE_ADDR produce an offset below four.
    assign offset   = bus.bus_addr - BASE_ADDR;
    assign addr_hit = (offset < 8'd4);
    assign reg_sel  = offset[1:0];
    assign wr_en    = addr_hit &  bus.bus_we;
    assign rd_en    = addr_hit & ~bus.bus_we;
    assign wdata    = bus_data[NUM_CH-1:0];

    assign raise    = bus.src_raise[NUM_CH-1:0];
    assign eligible = pending_q & mask_q;
    assign arb_ptr  = RR_MODE ? rr_ptr_q : '0;
    assign vector_inc = (vector_q == IDXW'(NUM_CH - 1)) ? '0 : vector_q + 1'b1;

    irq_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arbiter (
        .eligible  (eligible),
        .start_ptr (arb_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Capture: rising edge for edge-mode bits, raise-while-not-pending for level bits
    always_comb begin
        capture = (edge_q & raise & ~raise_d) | (~edge_q & raise & ~pending_q);
    end

    // Handshake FSM next state and the pending bit cleared by a cpu ack
    always_comb begin
        state_n = state_q;
        ack_clr = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.cpu_int_ack) begin
                    state_n           = ST_IDLE;
                    ack_clr[vector_q] = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Pending update: clears first, then a same-cycle capture wins
    always_comb begin
        w1c       = (wr_en && reg_sel == REG_PENDING) ? wdata : '0;
        pending_n = (pending_q & ~(w1c | ack_clr)) | capture;
    end

    // Raise history for edge detection; left running through reset so a
    // line held high across reset needs a fresh rising edge to be seen
    always_ff @(posedge clk) begin
        raise_d <= raise;
    end

    // FSM state, vector latch and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            vector_q    <= '0;
            vec_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            state_q <= state_n;
            if (state_q == ST_IDLE && any_valid) begin
                vector_q    <= winner;
                vec_valid_q <= 1'b1;
            end
            if (state_q == ST_REQ && bus.cpu_int_ack) begin
                vec_valid_q <= 1'b0;
                rr_ptr_q    <= vector_inc;
            end
        end
    end

    // Software-visible registers and the capture acknowledge pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            mask_q    <= '0;
            edge_q    <= '1;
            src_ack_q <= '0;
        end else begin
            pending_q <= pending_n;
            src_ack_q <= capture;
            if (wr_en && reg_sel == REG_MASK) begin
                mask_q <= wdata;
            end
            if (wr_en && reg_sel == REG_EDGE) begin
                edge_q <= wdata;
            end
        end
    end

    // Read data selection, zero-extended to the 8-bit bus
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_PENDING: rd_mux[NUM_CH-1:0] = pending_q;
            REG_MASK:    rd_mux[NUM_CH-1:0] = mask_q;
            REG_VECTOR: begin
                rd_mux[VEC_VALID_BIT] = vec_valid_q;
                rd_mux[IDXW-1:0]      = vector_q;
            end
            REG_EDGE:    rd_mux[NUM_CH-1:0] = edge_q;
            default:     rd_mux = '0;
        endcase
    end

    // Registered read path: the bus is driven only in the cycle after the address
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_oe     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_oe     <= rd_en;
            rd_data_q <= rd_mux;
        end
    end

    assign bus_data          = rd_oe ? rd_data_q : 8'bz;
    assign bus.src_ack       = 8'(src_ack_q);
    assign bus.cpu_int_raise = (state_q == ST_REQ);

endmodule

// File: tb/tb_bus_interrupt_controller.sv
// tb/tb_bus_interrupt_controller.sv - directed scoreboard bench for bus_interrupt_controller
module tb_bus_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic [7:0] src_raise;
    logic       cpu_ack0, cpu_ack1;
    logic       tb_oe;
    logic [7:0] tb_wdata;
    wire  [7:0] bus_data;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rdata;
    logic [7:0] rr_exp[6] = '{8'h80, 8'h81, 8'h86, 8'h80, 8'h81, 8'h86};
    logic [7:0] rr_bit[3] = '{8'h01, 8'h02, 8'h40};

    always #5 clk = ~clk;

    assign bus_data = tb_oe ? tb_wdata : 8'bz;

    bus_interrupt_controller_if if0 ();
    bus_interrupt_controller_if if1 ();

    assign if0.bus_addr    = bus_addr;
    assign if0.bus_we      = bus_we;
    assign if0.src_raise   = src_raise;
    assign if0.cpu_int_ack = cpu_ack0;
    assign if1.bus_addr    = bus_addr;
    assign if1.bus_we      = bus_we;
    assign if1.src_raise   = src_raise;
    assign if1.cpu_int_ack = cpu_ack1;

    bus_interrupt_controller #(.NUM_CH(8), .BASE_ADDR(8'hE0), .RR_MODE(1'b0)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .bus_data (bus_data),
        .bus      (if0)
    );

    bus_interrupt_controller #(.NUM_CH(8), .BASE_ADDR(8'hF0), .RR_MODE(1'b1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .bus_data (bus_data),
        .bus      (if1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus_addr = a;
        bus_we   = 1'b1;
        tb_wdata = d;
        tb_oe    = 1'b1;
        tick();
        bus_we   = 1'b0;
        tb_oe    = 1'b0;
        bus_addr = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        bus_addr = a;
        bus_we   = 1'b0;
        tick();
        d        = bus_data;
        bus_addr = 8'h00;
        tick();
    endtask

    function automatic logic raise_of(input bit sel);
        return sel ? if1.cpu_int_raise : if0.cpu_int_raise;
    endfunction

    task automatic service(input bit sel, input string tag);
        int         n;
        logic [7:0] expv;
        logic [7:0] base;
        base = sel ? 8'hF0 : 8'hE0;
        n    = 0;
        while (raise_of(sel) !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_raise"}, {7'b0, raise_of(sel)}, 8'h01);
        bus_read(base + 8'd2, rdata);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
        check({tag, "_vector"}, rdata, expv);
        if (sel) cpu_ack1 = 1'b1;
        else     cpu_ack0 = 1'b1;
        tick();
        cpu_ack0 = 1'b0;
        cpu_ack1 = 1'b0;
        check({tag, "_drop"}, {7'b0, raise_of(sel)}, 8'h00);
    endtask

    initial begin
        reset     = 1'b1;
        bus_addr  = 8'h00;
        bus_we    = 1'b0;
        src_raise = 8'h00;
        cpu_ack0  = 1'b0;
        cpu_ack1  = 1'b0;
        tb_oe     = 1'b0;
        tb_wdata  = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_raise", {7'b0, if0.cpu_int_raise}, 8'h00);
        check("rst_ack", if0.src_ack, 8'h00);
        check("rst_oe", {7'b0, dut0.rd_oe}, 8'h00);
        bus_read(8'hE0, rdata); check("rst_pending", rdata, 8'h00);
        bus_read(8'hE1, rdata); check("rst_mask", rdata, 8'h00);
        bus_read(8'hE2, rdata); check("rst_vector", rdata, 8'h00);
        bus_read(8'hE3, rdata); check("rst_edge", rdata, 8'hFF);

        // Single edge capture on channel 3
        bus_write(8'hE1, 8'hFF);
        src_raise = 8'h08;
        tick();
        check("t1_ack", if0.src_ack, 8'h08);
        check("t1_latency", {7'b0, if0.cpu_int_raise}, 8'h00);
        src_raise = 8'h00;
        tick();
        check("t1_raise", {7'b0, if0.cpu_int_raise}, 8'h01);
        check("t1_ack_pulse", if0.src_ack, 8'h00);
        bus_read(8'hE0, rdata); check("t1_pending", rdata, 8'h08);
        exp_q.push_back(8'h83);
        service(1'b0, "t1");
        bus_read(8'hE0, rdata); check("t1_cleared", rdata, 8'h00);

        // Fixed priority: channels 5 and 2 together
        src_raise = 8'h24;
        tick();
        check("t2_ack", if0.src_ack, 8'h24);
        src_raise = 8'h00;
        exp_q.push_back(8'h82);
        exp_q.push_back(8'h85);
        service(1'b0, "t2a");
        service(1'b0, "t2b");
        bus_read(8'hE0, rdata); check("t2_pending", rdata, 8'h00);

        // Level mode on channel 0: held raise captured once
        bus_write(8'hE3, 8'hFE);
        src_raise = 8'h01;
        tick();
        check("lvl_ack", if0.src_ack, 8'h01);
        tick();
        check("lvl_no_recapture", if0.src_ack, 8'h00);
        src_raise = 8'h00;
        exp_q.push_back(8'h80);
        service(1'b0, "lvl");
        bus_write(8'hE3, 8'hFF);

        // Masked pending does not raise until enabled
        bus_write(8'hE1, 8'h00);
        src_raise = 8'h10;
        tick();
        src_raise = 8'h00;
        tick();
        tick();
        check("t4_masked", {7'b0, if0.cpu_int_raise}, 8'h00);
        bus_read(8'hE0, rdata); check("t4_pending", rdata, 8'h10);
        bus_write(8'hE1, 8'h10);
        tick();
        tick();
        check("t4_unmask_raise", {7'b0, if0.cpu_int_raise}, 8'h01);
        exp_q.push_back(8'h84);
        service(1'b0, "t4");

        // W1C collides with a fresh capture on channel 0
        src_raise = 8'h01;
        bus_write(8'hE0, 8'h01);
        check("t5_ack", if0.src_ack, 8'h01);
        src_raise = 8'h00;
        bus_read(8'hE0, rdata); check("t5_capture_wins", rdata, 8'h01);
        bus_write(8'hE0, 8'h01);
        bus_read(8'hE0, rdata); check("t5_w1c", rdata, 8'h00);

        // Round-robin ordering on the second controller
        bus_write(8'hE1, 8'h00);
        bus_write(8'hF0, 8'hFF);
        bus_write(8'hF1, 8'hFF);
        bus_read(8'hF0, rdata); check("rr_cleared", rdata, 8'h00);
        src_raise = 8'h43;
        tick();
        src_raise = 8'h00;
        for (int i = 0; i < 6; i++) exp_q.push_back(rr_exp[i]);
        for (int i = 0; i < 6; i++) begin
            service(1'b1, "rr");
            if (i < 3) begin
                src_raise = rr_bit[i];
                tick();
                src_raise = 8'h00;
            end
        end
        check("rr_queue_empty", 8'(exp_q.size()), 8'h00);

        // Reset while a request is outstanding
        bus_write(8'hE1, 8'hFF);
        begin
            int n;
            n = 0;
            while (if0.cpu_int_raise !== 1'b1 && n < 8) begin
                tick();
                n++;
            end
        end
        check("t6_req", {7'b0, if0.cpu_int_raise}, 8'h01);
        reset     = 1'b1;
        src_raise = 8'h20;
        bus_addr  = 8'hE0;
        tick();
        check("t6_raise", {7'b0, if0.cpu_int_raise}, 8'h00);
        check("t6_oe", {7'b0, dut0.rd_oe}, 8'h00);
        check("t6_ack", if0.src_ack, 8'h00);
        reset    = 1'b0;
        bus_addr = 8'h00;
        tick();
        tick();
        bus_read(8'hE0, rdata); check("t6_pending", rdata, 8'h00);
        bus_read(8'hE1, rdata); check("t6_mask", rdata, 8'h00);
        bus_read(8'hE2, rdata); check("t6_vector", rdata, 8'h00);
        src_raise = 8'h00;

        // Out-of-range address leaves the bus undriven
        bus_addr = 8'hE4;
        tick();
        check("oor_oe0", {7'b0, dut0.rd_oe}, 8'h00);
        check("oor_oe1", {7'b0, dut1.rd_oe}, 8'h00);
        bus_addr = 8'h00;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_interrupt_controller.md
Name: bus_interrupt_controller

Overview:
- Memory-mapped, parametrised interrupt controller on the shared 8-bit processor bus.
- Aggregates NUM_CH peripheral raise/ack interrupt sources (mouse, timer, IR and future peripherals) into one processor interrupt line with a raise/ack handshake.
- Adds per-channel masking, edge/level capture, a readable vector register, and selectable fixed or round-robin priority.

Parameters:
- NUM_CH, 8: number of source channels; legal range 2..8.
- BASE_ADDR, 8'hE0: first of four consecutive bus register addresses.
- RR_MODE, 0: 0 = fixed priority (channel 0 highest); 1 = round-robin.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- BUS_DATA  inout  8  shared data bus; tri-stated unless this block is driving a read.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  bus write enable.
- SRC_RAISE  in  NUM_CH  peripheral raise lines; each is held until its SRC_ACK.
- SRC_ACK  out  NUM_CH  one-cycle capture acknowledge pulse per channel.
- CPU_INT_RAISE  out  1  interrupt request to the processor.
- CPU_INT_ACK  in  1  one-cycle acknowledge from the processor.

Behaviour:
- Registers, offset from BASE_ADDR; bits at or above NUM_CH read 0 and ignore writes:
  - +0 PENDING: read; write 1 to clear.
  - +1 MASK: read/write; 1 = enabled.
  - +2 VECTOR: read only; bit7 = valid, bits[2:0] = latched channel index.
  - +3 EDGE: read/write; 1 = rising-edge capture, 0 = level capture.
- Reset values: PENDING=0, MASK=0, EDGE=all 1, VECTOR=0, round-robin pointer=0, SRC_ACK=0, CPU_INT_RAISE=0, state IDLE, BUS_DATA=Z.
- Capture, edge mode: when SRC_RAISE[i] is high and was low the previous cycle, set PENDING[i] next cycle and pulse SRC_ACK[i] for one cycle in that same cycle.
- Capture, level mode: while SRC_RAISE[i] is high and PENDING[i] is 0, set PENDING[i] and pulse SRC_ACK[i]. The peripheral drops raise on ack, so there is no re-capture.
- Eligible set = PENDING & MASK.
- Arbitration:
  - RR_MODE=0: lowest eligible index wins.
  - RR_MODE=1: first eligible index at or after the pointer, wrapping NUM_CH-1 to 0. On CPU ack the pointer becomes (vector+1) mod NUM_CH.
- FSM, two states:
  - IDLE: if eligible is non-zero, latch the winner into VECTOR (valid=1), set CPU_INT_RAISE=1, go to REQ. Latency is one cycle from PENDING set to CPU_INT_RAISE.
  - REQ: VECTOR and CPU_INT_RAISE are held stable. Changes to MASK or PENDING do not withdraw the request.
  - On CPU_INT_ACK in REQ: clear PENDING[vector], CPU_INT_RAISE=0, valid=0, go to IDLE. IDLE lasts at least one cycle before any re-raise.
  - CPU_INT_ACK in IDLE is ignored.
- Bus write: on BUS_WE=1 with BUS_ADDR in range, the register updates next edge.
- Bus read: with BUS_WE=0 and BUS_ADDR in range, data and output enable are registered. BUS_DATA is driven in the following cycle only, otherwise Z.
- Simultaneous events: on the same bit, a new capture beats a W1C clear or a CPU-ack clear, and the bit stays 1. A write to MASK takes effect for arbitration the next cycle.
- Out-of-range address: no effect, no drive.
- RESET asserted mid-REQ: returns to reset values next edge. SRC_RAISE lines still high are re-captured after reset per EDGE=1. This requires a fresh rising edge, so software must pulse the peripheral or switch to level mode.
- Widths: vector index is clog2(NUM_CH) bits, zero-extended to 3 bits.

Decomposition:
- Shared package holds:
  - register offset constants (PENDING=0, MASK=1, VECTOR=2, EDGE=3);
  - FSM state encoding (IDLE, REQ);
  - VECTOR valid bit position (7).
- One sub-module, irq_rr_arbiter:
  - inputs: eligible vector and start pointer;
  - outputs: winner index and any-valid flag;
  - purely combinational rotate plus priority encode.
- Top block holds the registers, capture logic, FSM and bus interface.

Test Plan:
- Reset, then MASK=8'hFF. Pulse SRC_RAISE[3]. Expect SRC_ACK[3] pulse; PENDING reads 8'h08; CPU_INT_RAISE one cycle later; VECTOR reads 8'h83. After CPU_INT_ACK, PENDING=0 and CPU_INT_RAISE=0.
- RR_MODE=0, channels 5 and 2 raised together. Expect vector 2 first, then after ack vector 5.
- RR_MODE=1, channels 0, 1 and 6 held pending by repeated raises over 6 acks. Expect vector order 0,1,6,0,1,6.
- MASK=8'h00 with PENDING[4] set: no CPU_INT_RAISE. Write MASK=8'h10: CPU_INT_RAISE within 2 cycles, vector 4.
- W1C of 8'h01 in the same cycle as a new SRC_RAISE[0] edge: PENDING[0] remains 1. Reading offset +3 after reset returns 8'hFF.
- RESET asserted during REQ: next cycle CPU_INT_RAISE=0, PENDING=0, BUS_DATA=Z. A read of an out-of-range address leaves BUS_DATA undriven.
